// File: rtl/query_loader_pkg.sv
`default_nettype none
// ============================================================================
// query_loader_pkg : shared frame constants, parser state encoding and sizing
// Revision 1.0
// ============================================================================
package query_loader_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VID    = 3'd1,
        ST_KVAL   = 3'd2,
        ST_QUERY  = 3'd3,
        ST_CSUM   = 3'd4,
        ST_COMMIT = 3'd5
    } loader_state_t;

    // Header + vertex id + K + query words + checksum.
    function automatic int frame_bytes(input int dim);
        return 8 + 4 * dim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/query_loader_restart_pulser.sv
`default_nettype none
// ============================================================================
// query_loader_restart_pulser : load/count-down restart pulse for the search
// Revision 1.0
// ============================================================================
module query_loader_restart_pulser #(
    parameter int RST_CYCLES = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic load_in,
    output logic pulse_out
);
    localparam int              CW     = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0]   c_load = CW'(RST_CYCLES);
    localparam logic [CW-1:0]   c_one  = CW'(1);

    logic [CW-1:0] r_cnt;

    // Pulse holds high from reset until the first load has fully counted out.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt     <= '0;
            pulse_out <= 1'b1;
        end else if (load_in) begin
            r_cnt     <= c_load;
            pulse_out <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt     <= r_cnt - 1'b1;
            pulse_out <= (r_cnt != c_one);
        end
    end

endmodule
`default_nettype wire

// File: rtl/query_loader.sv
`default_nettype none
// ============================================================================
// query_loader : framed byte-stream parser committing checksum-valid queries
// Revision 1.0
// ============================================================================
module query_loader
    import query_loader_pkg::*;
#(
    parameter int DIM        = 2,
    parameter int TIMEOUT    = 1_000_000,
    parameter int RST_CYCLES = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    output logic [31:0]           vertex_id_out,
    output logic [15:0]           k_out,
    output logic [DIM-1:0][31:0]  query_out,
    output logic                  search_rst_out,
    output logic                  frame_ok_out,
    output logic                  frame_err_out,
    output logic                  busy_out
);
    localparam int             WCW         = $clog2(DIM) + 1;
    localparam int             IW          = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] c_last_word = WCW'(DIM - 1);
    localparam logic [IW-1:0]  c_timeout   = IW'(TIMEOUT);

    loader_state_t        r_state;
    logic [1:0]           r_byte_cnt;
    logic [WCW-1:0]       r_word_cnt;
    logic [IW-1:0]        r_idle_cnt;
    logic [7:0]           r_xor;
    logic [31:0]          r_vid_sh;
    logic [15:0]          r_k_sh;
    logic [DIM*32-1:0]    r_query_sh;
    logic                 w_commit;

    assign w_commit = (r_state == ST_COMMIT);

    // Fields arrive LSB first, so shadows shift right and take the new byte at the top.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state       <= ST_IDLE;
            r_byte_cnt    <= '0;
            r_word_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_xor         <= '0;
            r_vid_sh      <= '0;
            r_k_sh        <= '0;
            r_query_sh    <= '0;
            vertex_id_out <= '0;
            k_out         <= '0;
            query_out     <= '0;
            frame_ok_out  <= 1'b0;
            frame_err_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            frame_ok_out  <= 1'b0;
            frame_err_out <= 1'b0;
            busy_out      <= (r_state != ST_IDLE);

            if (r_state == ST_IDLE || byte_valid_in) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (r_state != ST_IDLE && r_idle_cnt == c_timeout) begin
                r_state       <= ST_IDLE;
                frame_err_out <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (byte_valid_in && byte_in == FRAME_HDR) begin
                            r_state    <= ST_VID;
                            r_xor      <= '0;
                            r_byte_cnt <= '0;
                            r_word_cnt <= '0;
                        end
                    end
                    ST_VID: begin
                        if (byte_valid_in) begin
                            r_vid_sh   <= {byte_in, r_vid_sh[31:8]};
                            r_xor      <= r_xor ^ byte_in;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_state <= ST_KVAL;
                            end
                        end
                    end
                    ST_KVAL: begin
                        if (byte_valid_in) begin
                            r_k_sh <= {byte_in, r_k_sh[15:8]};
                            r_xor  <= r_xor ^ byte_in;
                            if (r_byte_cnt[0]) begin
                                r_byte_cnt <= '0;
                                r_state    <= ST_QUERY;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                            end
                        end
                    end
                    ST_QUERY: begin
                        if (byte_valid_in) begin
                            r_query_sh <= {byte_in, r_query_sh[DIM*32-1:8]};
                            r_xor      <= r_xor ^ byte_in;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                                if (r_word_cnt == c_last_word) begin
                                    r_state <= ST_CSUM;
                                end
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (byte_valid_in) begin
                            if (byte_in == r_xor) begin
                                r_state <= ST_COMMIT;
                            end else begin
                                r_state       <= ST_IDLE;
                                frame_err_out <= 1'b1;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        vertex_id_out <= r_vid_sh;
                        k_out         <= r_k_sh;
                        query_out     <= r_query_sh;
                        frame_ok_out  <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    query_loader_restart_pulser #(
        .RST_CYCLES (RST_CYCLES)
    ) u_restart_pulser (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_in   (w_commit),
        .pulse_out (search_rst_out)
    );

endmodule
`default_nettype wire
